core_ctrl: RTL and testbench

- Multicycle sequencer for the RV32I core.
- Consumes the instruction-decoder fields (opcode, fn3, fn7) and the ALU branch compare.
- Drives IR/PC/regfile write enables, datapath muxes, ALU op, and req/ready handshakes to instruction and data memory.
- One instruction in flight; sits between the decoder and the datapath/memory ports.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/core_ctrl.sv | 133 +++++++++++++
 tb/tb_core_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: states, opcodes,
// PC/writeback mux selects and ALU operation decode.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  function automatic logic opcode_legal(input logic [6:0] opcode,
                                        input logic [2:0] fn3);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: ok = 1'b1;
      OPC_JALR:                               ok = (fn3 == 3'b000);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only shifts-right carry the alt bit for immediates; elsewhere fn7 is imm data.
  function automatic logic [3:0] alu_op_dec(input logic [6:0] opcode,
                                            input logic [2:0] fn3,
                                            input logic [6:0] fn7);
    logic [3:0] op;
    op = ALU_ADD;
    case (opcode)
      OPC_OP:     op = {fn7[5], fn3};
      OPC_OPIMM:  op = {(fn3 == 3'b101) ? fn7[5] : 1'b0, fn3};
      OPC_BRANCH: op = {1'b1, fn3};
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_ctrl.sv
// Multicycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with a
// sticky TRAP on illegal opcodes. Outputs are combinational from state and fields.
module core_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] fn3,
  input  logic [6:0] fn7,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_srca,
  output logic       alu_srcb,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [2:0] state_o
);

  state_t state, state_nxt;
  logic   illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_srca  = 1'b0;
    alu_srcb  = 1'b0;
    alu_op    = ALU_ADD;

    // Reset masks every output, including any stray ready in the request states.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we     = 1'b1;
            state_nxt = S_DECODE;
          end
        end

        S_DECODE: begin
          state_nxt = opcode_legal(opcode, fn3) ? S_EXEC : S_TRAP;
        end

        S_EXEC: begin
          alu_srca = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
          alu_srcb = !((opcode == OPC_OP) || (opcode == OPC_BRANCH));
          alu_op   = alu_op_dec(opcode, fn3, fn7);
          if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
            state_nxt = S_MEM;
          end else if (opcode == OPC_BRANCH) begin
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_REL : PC_PLUS4;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OPC_STORE);
          if (dmem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_we     = 1'b1;
              pc_sel    = PC_PLUS4;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end
        end

        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (opcode)
            OPC_JAL:  pc_sel = PC_REL;
            OPC_JALR: pc_sel = PC_JALR;
            default:  pc_sel = PC_PLUS4;
          endcase
          case (opcode)
            OPC_LOAD:           wb_sel = WB_LOAD;
            OPC_JAL, OPC_JALR:  wb_sel = WB_PC4;
            OPC_LUI:            wb_sel = WB_IMM;
            default:            wb_sel = WB_ALU;
          endcase
          state_nxt = S_FETCH;
        end

        S_TRAP: begin
          state_nxt = S_TRAP;
        end

        default: begin
          state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign illegal = illegal_q & ~rst;
  assign state_o = state;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: walks each instruction class cycle by cycle and
// compares state and the full output bundle against hand-derived values.
module tb_core_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  logic       br_taken;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       alu_srca;
  logic       alu_srcb;
  logic [3:0] alu_op;
  logic       illegal;
  logic [2:0] state_o;

  int n_assert = 0;
  int n_fail   = 0;

  core_ctrl #(.RESET_STATE(3'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .fn3        (fn3),
    .fn7        (fn7),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
                 wb_sel, alu_srca, alu_srcb, alu_op, illegal};

  function automatic logic [16:0] o(input logic ireq, input logic dreq,
                                    input logic dwe, input logic irwe,
                                    input logic pcwe, input logic [1:0] pcs,
                                    input logic rwe, input logic [1:0] wbs,
                                    input logic sa, input logic sb,
                                    input logic [3:0] aop, input logic ill);
    return {ireq, dreq, dwe, irwe, pcwe, pcs, rwe, wbs, sa, sb, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; settle, compare, then advance one clock.
  task automatic step(input string tag, input logic [2:0] st, input logic [16:0] e);
    #1;
    chk({tag, "_state"}, {14'd0, state_o}, {14'd0, st});
    chk(tag, outs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    fn3    = f3;
    fn7    = f7;
  endtask

  // FETCH with optional wait cycles, then DECODE with stray readies asserted.
  task automatic do_fetch(input string tag, input int waits);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    for (int i = 0; i < waits; i++)
      step({tag, "_fwait"}, 3'd0, o(1,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));
    imem_ready = 1'b1;
    step({tag, "_fetch"}, 3'd0, o(1,0,0,1,0,2'b00,0,2'b00,0,0,4'b0000,0));
    dmem_ready = 1'b1;
    step({tag, "_dec"}, 3'd1, '0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    set_ins(7'b0, 3'b0, 7'b0);
    #1;
    chk("rst_pre_edge", outs, '0);
    @(posedge clk); #1;
    step("rst_held", 3'd0, '0);
    rst = 1'b0;

    // ADD
    set_ins(7'b0110011, 3'b000, 7'b0000000);
    do_fetch("add", 0);
    step("add_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));
    step("add_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // SUB
    set_ins(7'b0110011, 3'b000, 7'b0100000);
    do_fetch("sub", 0);
    step("sub_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,0,4'b1000,0));
    step("sub_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // SRAI
    set_ins(7'b0010011, 3'b101, 7'b0100000);
    do_fetch("srai", 0);
    step("srai_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b1101,0));
    step("srai_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // SRLI
    set_ins(7'b0010011, 3'b101, 7'b0000000);
    do_fetch("srli", 0);
    step("srli_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0101,0));
    step("srli_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // SLTI with imm bits that look like fn7[5]
    set_ins(7'b0010011, 3'b010, 7'b0100000);
    do_fetch("slti", 0);
    step("slti_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0010,0));
    step("slti_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // LOAD: 2 fetch waits, 3 data waits -> 10 cycles
    set_ins(7'b0000011, 3'b010, 7'b0000000);
    do_fetch("load", 2);
    step("load_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0000,0));
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      step("load_mwait", 3'd3, o(0,1,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));
    imem_ready = 1'b0;
    dmem_ready = 1'b1;
    step("load_mem", 3'd3, o(0,1,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));
    step("load_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b01,0,0,4'b0000,0));
    dmem_ready = 1'b0;

    // STORE zero-wait
    set_ins(7'b0100011, 3'b010, 7'b0000000);
    do_fetch("store", 0);
    step("store_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0000,0));
    dmem_ready = 1'b1;
    step("store_mem", 3'd3, o(0,1,1,0,1,2'b00,0,2'b00,0,0,4'b0000,0));
    dmem_ready = 1'b0;

    // BEQ taken, then BNE not taken
    set_ins(7'b1100011, 3'b000, 7'b0000000);
    do_fetch("beq", 0);
    br_taken = 1'b1;
    step("beq_ex", 3'd2, o(0,0,0,0,1,2'b01,0,2'b00,0,0,4'b1000,0));
    br_taken = 1'b0;
    set_ins(7'b1100011, 3'b001, 7'b0000000);
    do_fetch("bne", 0);
    step("bne_ex", 3'd2, o(0,0,0,0,1,2'b00,0,2'b00,0,0,4'b1001,0));

    // JALR
    set_ins(7'b1100111, 3'b000, 7'b0000000);
    do_fetch("jalr", 0);
    step("jalr_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0000,0));
    step("jalr_wb", 3'd4, o(0,0,0,0,1,2'b10,1,2'b10,0,0,4'b0000,0));

    // JAL
    set_ins(7'b1101111, 3'b101, 7'b0100000);
    do_fetch("jal", 0);
    step("jal_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,1,1,4'b0000,0));
    step("jal_wb", 3'd4, o(0,0,0,0,1,2'b01,1,2'b10,0,0,4'b0000,0));

    // LUI
    set_ins(7'b0110111, 3'b000, 7'b0000000);
    do_fetch("lui", 0);
    step("lui_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0000,0));
    step("lui_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b11,0,0,4'b0000,0));

    // AUIPC
    set_ins(7'b0010111, 3'b000, 7'b0000000);
    do_fetch("auipc", 0);
    step("auipc_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,1,1,4'b0000,0));
    step("auipc_wb", 3'd4, o(0,0,0,0,1,2'b00,1,2'b00,0,0,4'b0000,0));

    // Illegal opcode: TRAP held for 20 cycles with readies toggling
    set_ins(7'b1111111, 3'b000, 7'b0000000);
    do_fetch("ill", 0);
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      dmem_ready = i[1];
      step("trap_hold", 3'd5, o(0,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,1));
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst = 1'b1;
    step("trap_rst", 3'd5, '0);
    rst = 1'b0;
    step("after_rst", 3'd0, o(1,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));

    // JALR with nonzero fn3 is illegal
    set_ins(7'b1100111, 3'b001, 7'b0000000);
    do_fetch("jalr_bad", 0);
    step("jalr_bad_trap", 3'd5, o(0,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,1));
    rst = 1'b1;
    step("jalr_bad_rst", 3'd5, '0);
    rst = 1'b0;

    // Reset while a load is waiting in MEM
    set_ins(7'b0000011, 3'b000, 7'b0000000);
    do_fetch("abort", 0);
    step("abort_ex", 3'd2, o(0,0,0,0,0,2'b00,0,2'b00,0,1,4'b0000,0));
    step("abort_mem", 3'd3, o(0,1,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));
    rst = 1'b1;
    dmem_ready = 1'b1;
    step("abort_rst", 3'd3, '0);
    rst = 1'b0;
    dmem_ready = 1'b0;
    step("abort_fetch", 3'd0, o(1,0,0,0,0,2'b00,0,2'b00,0,0,4'b0000,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
